// File: rtl/instruction_queue_param_if.sv
// Handshake and payload bundle between an instruction producer and the queue.
// The slave modport is the queue side; the master modport is the producer/consumer side.
interface instruction_queue_param_if #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 48
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   // enqueue side
   logic              valid_in;
   logic [3:0]        MajorOpcode_in;
   logic [4:0]        Source1_in;
   logic [4:0]        Source2_in;
   logic [1:0]        OffsetScale_in;
   logic [4:0]        Destination_in;
   logic [3:0]        MinorOpcode_in;
   logic              HasAddress_in;
   logic [ADDR_W-1:0] Address_in;
   logic              OffsetSub_in;
   logic              stall_in;
   logic              flush;

   // head / status side
   logic              valid_out;
   logic [3:0]        MajorOpcode_out;
   logic [4:0]        Source1_out;
   logic [4:0]        Source2_out;
   logic [1:0]        OffsetScale_out;
   logic [4:0]        Destination_out;
   logic [3:0]        MinorOpcode_out;
   logic              HasAddress_out;
   logic [ADDR_W-1:0] Address_out;
   logic              OffsetSub_out;
   logic              stall_out;
   logic              almost_full;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  valid_in, MajorOpcode_in, Source1_in, Source2_in, OffsetScale_in,
             Destination_in, MinorOpcode_in, HasAddress_in, Address_in, OffsetSub_in,
             stall_in, flush,
      output valid_out, MajorOpcode_out, Source1_out, Source2_out, OffsetScale_out,
             Destination_out, MinorOpcode_out, HasAddress_out, Address_out, OffsetSub_out,
             stall_out, almost_full, count
   );

   modport master (
      output valid_in, MajorOpcode_in, Source1_in, Source2_in, OffsetScale_in,
             Destination_in, MinorOpcode_in, HasAddress_in, Address_in, OffsetSub_in,
             stall_in, flush,
      input  valid_out, MajorOpcode_out, Source1_out, Source2_out, OffsetScale_out,
             Destination_out, MinorOpcode_out, HasAddress_out, Address_out, OffsetSub_out,
             stall_out, almost_full, count
   );
endinterface

// File: rtl/instruction_queue_param.sv
// Show-ahead circular instruction queue: DEPTH entries, head fields presented
// straight from storage, full/almost-full/occupancy derived from registered state.
module instruction_queue_param #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned ADDR_W   = 48,
   parameter int unsigned AF_LEVEL = DEPTH - 2
) (
   input logic                     clk,
   input logic                     rst_n,
   instruction_queue_param_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

   typedef struct packed {
      logic [3:0]        major_opcode;
      logic [4:0]        source1;
      logic [4:0]        source2;
      logic [1:0]        offset_scale;
      logic [4:0]        destination;
      logic [3:0]        minor_opcode;
      logic              has_address;
      logic [ADDR_W-1:0] address;
      logic              offset_sub;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic   full_c;
   logic   empty_c;
   logic   enq_c;
   logic   deq_c;
   entry_t wr_entry_c;
   entry_t rd_entry_c;

   // Handshake qualification; full only depends on registered occupancy.
   always_comb begin
      full_c  = (count_q == FULL_CNT);
      empty_c = (count_q == '0);
      enq_c   = bus.valid_in && !full_c;
      deq_c   = !empty_c && !bus.stall_in;
   end

   always_comb begin
      wr_entry_c              = '0;
      wr_entry_c.major_opcode = bus.MajorOpcode_in;
      wr_entry_c.source1      = bus.Source1_in;
      wr_entry_c.source2      = bus.Source2_in;
      wr_entry_c.offset_scale = bus.OffsetScale_in;
      wr_entry_c.destination  = bus.Destination_in;
      wr_entry_c.minor_opcode = bus.MinorOpcode_in;
      wr_entry_c.has_address  = bus.HasAddress_in;
      wr_entry_c.address      = bus.Address_in;
      wr_entry_c.offset_sub   = bus.OffsetSub_in;
   end

   // Next pointer/occupancy; flush overrides any same-cycle transfer.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq_c) tail_d = tail_q + PTR_W'(1);
         if (deq_c) head_d = head_q + PTR_W'(1);
         case ({enq_c, deq_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is cleared on reset so the show-ahead outputs are never X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (enq_c && !bus.flush) begin
         mem[tail_q] <= wr_entry_c;
      end
   end

   always_comb rd_entry_c = mem[head_q];

   assign bus.valid_out       = !empty_c;
   assign bus.stall_out       = full_c;
   assign bus.almost_full     = (count_q >= AF_CNT);
   assign bus.count           = count_q;
   assign bus.MajorOpcode_out = rd_entry_c.major_opcode;
   assign bus.Source1_out     = rd_entry_c.source1;
   assign bus.Source2_out     = rd_entry_c.source2;
   assign bus.OffsetScale_out = rd_entry_c.offset_scale;
   assign bus.Destination_out = rd_entry_c.destination;
   assign bus.MinorOpcode_out = rd_entry_c.minor_opcode;
   assign bus.HasAddress_out  = rd_entry_c.has_address;
   assign bus.Address_out     = rd_entry_c.address;
   assign bus.OffsetSub_out   = rd_entry_c.offset_sub;

   // Occupancy must stay within the physical depth.
   property p_count_bounded;
      @(posedge clk) disable iff (!rst_n) count_q <= FULL_CNT;
   endproperty
   a_count_bounded: assert property (p_count_bounded);

endmodule

// File: tb/tb_instruction_queue_param.sv
// Scoreboard bench for instruction_queue_param: an independent occupancy/order
// model predicts every dequeued entry and the status outputs after each edge.
module tb_instruction_queue_param;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned ADDR_W = 48;

   typedef struct packed {
      logic [3:0]        maj;
      logic [4:0]        s1;
      logic [4:0]        s2;
      logic [1:0]        osc;
      logic [4:0]        dst;
      logic [3:0]        mnr;
      logic              has;
      logic [ADDR_W-1:0] addr;
      logic              osub;
   } ent_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   ent_t drv_e;
   ent_t sb[$];
   ent_t exp_q[$];
   ent_t got_q[$];

   instruction_queue_param_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

   instruction_queue_param #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AF_LEVEL(DEPTH - 2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ent_t head_now();
      return {bus.MajorOpcode_out, bus.Source1_out, bus.Source2_out, bus.OffsetScale_out,
              bus.Destination_out, bus.MinorOpcode_out, bus.HasAddress_out,
              bus.Address_out, bus.OffsetSub_out};
   endfunction

   function automatic ent_t rand_ent(input logic [ADDR_W-1:0] a);
      logic [95:0] t;
      ent_t        r;
      t      = {$urandom(), $urandom(), $urandom()};
      r      = t[74:0];
      r.addr = a;
      return r;
   endfunction

   task automatic drive(input logic v, input logic st, input logic fl);
      bus.valid_in       = v;
      bus.stall_in       = st;
      bus.flush          = fl;
      bus.MajorOpcode_in = drv_e.maj;
      bus.Source1_in     = drv_e.s1;
      bus.Source2_in     = drv_e.s2;
      bus.OffsetScale_in = drv_e.osc;
      bus.Destination_in = drv_e.dst;
      bus.MinorOpcode_in = drv_e.mnr;
      bus.HasAddress_in  = drv_e.has;
      bus.Address_in     = drv_e.addr;
      bus.OffsetSub_in   = drv_e.osub;
   endtask

   // Advance one edge; the model decides transfers from its own occupancy.
   task automatic step(output logic enq);
      logic deq;
      enq = 1'b0;
      if (bus.flush) begin
         sb.delete();
      end else begin
         deq = (sb.size() != 0) && !bus.stall_in;
         enq = bus.valid_in && (sb.size() < DEPTH);
         if (deq) begin
            got_q.push_back(head_now());
            exp_q.push_back(sb.pop_front());
         end
         if (enq) sb.push_back(drv_e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drv_e = '0;
      drive(1'b0, 1'b0, 1'b0);
      #12;
      n_checks++;
      if ({bus.valid_out, bus.stall_out, bus.almost_full} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got v/s/af=%b%b%b expected 000", bus.valid_out, bus.stall_out, bus.almost_full);
      end
      n_checks++;
      if (bus.count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d expected 0", bus.count);
      end
      n_checks++;
      if (head_now() !== ent_t'(0)) begin
         n_fail++;
         $display("FAIL reset_fields: got %h expected 0", head_now());
      end
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic test_single_entry();
      logic acc;
      ent_t e;
      e     = {4'b1010, 5'b11111, 5'b01110, 2'b11, 5'b11011, 4'b1001, 1'b1, 48'd98, 1'b1};
      drv_e = e;
      drive(1'b1, 1'b1, 1'b0);
      step(acc);
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (bus.valid_out !== 1'b1 || bus.count !== 4'd1) begin
         n_fail++;
         $display("FAIL single_state: got valid=%b count=%0d expected valid=1 count=1", bus.valid_out, bus.count);
      end
      n_checks++;
      if (head_now() !== e) begin
         n_fail++;
         $display("FAIL single_fields: got %h expected %h", head_now(), e);
      end
      drive(1'b0, 1'b0, 1'b0);
      step(acc);
      n_checks++;
      if (bus.count !== 4'(sb.size()) || bus.valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL single_drain: got count=%0d valid=%b expected 0 0", bus.count, bus.valid_out);
      end
      while (exp_q.size() != 0) begin
         ent_t x, g;
         x = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== x) begin
            n_fail++;
            $display("FAIL single_pop: got %h expected %h", g, x);
         end
      end
   endtask

   task automatic test_fill();
      logic acc;
      int   m;
      for (int i = 0; i < 9; i++) begin
         drv_e = rand_ent(48'(100 + i));
         drive(1'b1, 1'b1, 1'b0);
         step(acc);
         m = (i + 1 < 8) ? i + 1 : 8;
         n_checks++;
         if (bus.count !== 4'(m) || bus.almost_full !== (m >= 6) || bus.stall_out !== (m == 8)) begin
            n_fail++;
            $display("FAIL fill_%0d: got count=%0d af=%b stall=%b expected count=%0d af=%b stall=%b",
                     i, bus.count, bus.almost_full, bus.stall_out, m, (m >= 6), (m == 8));
         end
      end
      n_checks++;
      if (sb.size() != 8 || acc !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_refused: model size=%0d last accept=%b expected 8 0", sb.size(), acc);
      end
   endtask

   task automatic test_full_dequeue();
      logic acc;
      int   guard;
      drv_e = rand_ent(48'd200);
      drive(1'b1, 1'b0, 1'b0);
      step(acc);
      n_checks++;
      if (bus.count !== 4'd7 || bus.stall_out !== 1'b0 || acc !== 1'b0) begin
         n_fail++;
         $display("FAIL full_deq: got count=%0d stall=%b expected count=7 stall=0", bus.count, bus.stall_out);
      end
      drv_e = rand_ent(48'd201);
      drive(1'b1, 1'b0, 1'b0);
      step(acc);
      n_checks++;
      if (bus.count !== 4'd7 || acc !== 1'b1) begin
         n_fail++;
         $display("FAIL full_next_enq: got count=%0d expected 7", bus.count);
      end
      drive(1'b0, 1'b0, 1'b0);
      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         step(acc);
         guard++;
      end
      n_checks++;
      if (bus.valid_out !== 1'b0 || guard >= 50) begin
         n_fail++;
         $display("FAIL full_drain: got valid=%b after %0d cycles expected 0", bus.valid_out, guard);
      end
      while (exp_q.size() != 0) begin
         ent_t x, g;
         x = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== x) begin
            n_fail++;
            $display("FAIL full_pop: got %h expected %h", g, x);
         end
      end
   endtask

   task automatic test_wrap_order();
      logic acc;
      int   next;
      int   c;
      int   seen;
      next = 0;
      c    = 0;
      while ((next < 20 || sb.size() != 0) && c < 300) begin
         drv_e = rand_ent(48'(next));
         drive(next < 20, ((c / 3) % 2) == 1, 1'b0);
         step(acc);
         if (acc) next++;
         c++;
      end
      drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (c >= 300 || exp_q.size() != 20) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d dequeued in %0d cycles expected 20", exp_q.size(), c);
      end
      seen = 0;
      while (exp_q.size() != 0) begin
         ent_t x, g;
         x = exp_q.pop_front();
         g = got_q.pop_front();
         n_checks++;
         if (g !== x || g.addr !== 48'(seen)) begin
            n_fail++;
            $display("FAIL wrap_pop_%0d: got %h expected %h", seen, g, x);
         end
         seen++;
      end
   endtask

   task automatic test_flush_reset();
      logic acc;
      for (int i = 0; i < 5; i++) begin
         drv_e = rand_ent(48'(300 + i));
         drive(1'b1, 1'b1, 1'b0);
         step(acc);
      end
      n_checks++;
      if (bus.count !== 4'd5) begin
         n_fail++;
         $display("FAIL flush_pre: got count=%0d expected 5", bus.count);
      end
      drv_e = rand_ent(48'd399);
      drive(1'b1, 1'b0, 1'b1);
      step(acc);
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (bus.count !== 4'(sb.size()) || bus.valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_post: got count=%0d valid=%b expected 0 0", bus.count, bus.valid_out);
      end
      for (int i = 0; i < 5; i++) begin
         drv_e = rand_ent(48'(400 + i));
         drive(1'b1, 1'b1, 1'b0);
         step(acc);
      end
      drive(1'b0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      n_checks++;
      if (bus.count !== 4'd0 || {bus.valid_out, bus.stall_out, bus.almost_full} !== 3'b000 ||
          head_now() !== ent_t'(0)) begin
         n_fail++;
         $display("FAIL midreset: got count=%0d flags=%b%b%b head=%h expected all 0",
                  bus.count, bus.valid_out, bus.stall_out, bus.almost_full, head_now());
      end
      rst_n = 1'b1;
      drv_e = rand_ent(48'd500);
      drive(1'b1, 1'b1, 1'b0);
      step(acc);
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (bus.count !== 4'd1 || head_now() !== drv_e) begin
         n_fail++;
         $display("FAIL post_reset_enq: got count=%0d head=%h expected 1 %h", bus.count, head_now(), drv_e);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single_entry();
      test_fill();
      test_full_dequeue();
      test_wrap_order();
      test_flush_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/instruction_queue_param.md
INSTRUCTION_QUEUE_PARAM -- requirements
Module: instruction_queue_param

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; power of two, >= 2.
REQ-002 Parameter ADDR_W, default 48, width of Address field.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts; range 1..DEPTH.
REQ-004 Ports (clock and reset first):
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  valid_in  in  1  enqueue request
  MajorOpcode_in  in  4  major opcode
  Source1_in  in  5  source register 1
  Source2_in  in  5  source register 2
  OffsetScale_in  in  2  offset scale
  Destination_in  in  5  destination register
  MinorOpcode_in  in  4  minor opcode
  HasAddress_in  in  1  address field valid
  Address_in  in  ADDR_W  address
  OffsetSub_in  in  1  offset subtract
  stall_in  in  1  downstream stall; head not consumed
  flush  in  1  discard all entries
  valid_out  out  1  head entry valid
  MajorOpcode_out .. OffsetSub_out  out  same widths as inputs  head entry fields
  stall_out  out  1  queue full; upstream enqueue refused
  almost_full  out  1  count >= AF_LEVEL
  count  out  $clog2(DEPTH)+1  current occupancy
REQ-005 The block has one clock; reset is asynchronous and active-low.

Function
REQ-006 Storage: DEPTH-entry circular buffer, head/tail pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0, plus occupancy counter.
REQ-007 Enqueue occurs at a rising edge when valid_in=1 and stall_out=0; all nine fields written at tail, tail increments.
REQ-008 Dequeue occurs at a rising edge when valid_out=1 and stall_in=0; head increments.
REQ-009 Output fields show head entry combinationally from storage (show-ahead); valid_out = (count != 0).
REQ-010 Enqueue-to-output latency: an entry enqueued into an empty queue at edge N is presented with valid_out=1 after edge N.
REQ-011 stall_out = (count == DEPTH), derived from registered state only; no combinational path from stall_in or valid_in.
REQ-012 Full with simultaneous dequeue: enqueue still refused that cycle; dequeue proceeds; count becomes DEPTH-1.
REQ-013 Empty with valid_in=1: enqueue proceeds, no dequeue (valid_out=0 that cycle); count becomes 1.
REQ-014 Simultaneous enqueue and dequeue when 0 < count < DEPTH: both occur, count unchanged.
REQ-015 count increments by 1 on enqueue-only, decrements by 1 on dequeue-only; never exceeds DEPTH, never below 0.
REQ-016 flush=1 at a rising edge: head, tail, count cleared to 0; any same-cycle enqueue/dequeue ignored; flush has priority.
REQ-017 Output field values while valid_out=0 are don't-care for consumers but shall not be X after reset.
REQ-018 FIFO order preserved across pointer wrap-around.

Reset
REQ-019 rst_n low asynchronously clears head, tail, count and all storage entries to 0.
REQ-020 During and immediately after reset: valid_out=0, stall_out=0, almost_full=0, count=0, all field outputs 0.
REQ-021 Reset asserted mid-operation discards all entries; first edge after rst_n release accepts enqueue normally.

Verification
REQ-022 Single entry: reset, enqueue MajorOpcode=4'b1010, Source1=5'b11111, Source2=5'b01110, OffsetScale=2'b11, Destination=5'b11011, MinorOpcode=4'b1001, HasAddress=1, Address=98, OffsetSub=1 -> next cycle valid_out=1, all outputs match, count=1.
REQ-023 Fill (DEPTH=8): 8 enqueues with stall_in=1 -> stall_out=1 after 8th, almost_full=1 from count=6, 9th enqueue refused, count=8.
REQ-024 Full plus dequeue: at count=8 drive valid_in=1, stall_in=0 -> dequeue only, count=7, stall_out=0; next cycle enqueue accepted.
REQ-025 Wrap/order: stream 20 entries with Address=0..19, stall_in toggling every 3 cycles -> outputs Address 0..19 in order, no loss or duplication.
REQ-026 Flush/reset: at count=5 assert flush with valid_in=1 -> count=0, valid_out=0; repeat at count=5 with rst_n pulsed low between edges -> all outputs 0 immediately.
